// File: rtl/branch_predictor.sv
// Fetch-side direction predictor: a table of 2-bit saturating counters plus an
// in-order FIFO of outstanding predictions that is retired and trained on resolve.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pred_valid_i,
  input  logic [XLEN-1:0]            pred_pc_i,
  output logic                       pred_ready_o,
  output logic                       pred_take_o,
  input  logic                       res_valid_i,
  input  logic                       res_take_i,
  output logic                       mispredict_o,
  output logic                       underflow_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [CNT_W-1:0]           mispred_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_q       [ENTRIES];
  logic [IDX_BITS-1:0] fifo_idx_q  [DEPTH];
  logic                fifo_pred_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;
  logic                mispredict_q, underflow_q;
  logic [CNT_W-1:0]    mispred_cnt_q;

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] head_idx;
  logic                head_pred;
  logic [1:0]          head_ctr;
  logic [1:0]          ctr_next;
  logic                full, empty, push, pop, mispred;
  logic                unused_pc_bits;

  assign pred_idx       = pred_pc_i[IDX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_BITS+2], pred_pc_i[1:0]};

  // The table is read combinationally, so a same-cycle update to the same
  // index is seen only by the next prediction.
  assign pred_take_o  = ctr_q[pred_idx][1];

  assign full         = (occ_q == OCC_W'(DEPTH));
  assign empty        = (occ_q == '0);
  assign pred_ready_o = ~full;
  assign push         = pred_valid_i & ~full;
  assign pop          = res_valid_i & ~empty;

  assign head_idx     = fifo_idx_q[rd_ptr_q];
  assign head_pred    = fifo_pred_q[rd_ptr_q];
  assign head_ctr     = ctr_q[head_idx];
  assign mispred      = pop & (res_take_i != head_pred);

  always_comb begin
    ctr_next = head_ctr;
    if (res_take_i) begin
      if (head_ctr != 2'b11) ctr_next = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) ctr_next = head_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (pop) begin
      ctr_q[head_idx] <= ctr_next;
    end
  end

  // NOTE: payload storage needs no reset; occ_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= pred_idx;
      fifo_pred_q[wr_ptr_q] <= pred_take_o;
    end
  end

  // A mispredict squashes every younger entry, including one pushed this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (mispred) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_q  <= 1'b0;
      underflow_q   <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= mispred;
      underflow_q  <= res_valid_i & empty;
      if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign mispredict_o  = mispredict_q;
  assign underflow_o   = underflow_q;
  assign occupancy_o   = occ_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a queue-and-array
// reference model of the predictor's rules.
module tb_branch_predictor;

  localparam int DEPTH   = 4;
  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_ready;
  logic        pred_take;
  logic        res_valid = 1'b0;
  logic        res_take = 1'b0;
  logic        mispredict;
  logic        underflow;
  logic [2:0]  occupancy;
  logic [31:0] mispred_cnt;

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pred_valid_i  (pred_valid),
    .pred_pc_i     (pred_pc),
    .pred_ready_o  (pred_ready),
    .pred_take_o   (pred_take),
    .res_valid_i   (res_valid),
    .res_take_i    (res_take),
    .mispredict_o  (mispredict),
    .underflow_o   (underflow),
    .occupancy_o   (occupancy),
    .mispred_cnt_o (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic pred;
  } entry_t;

  int      m_ctr [ENTRIES];
  entry_t  m_q[$];
  longint  m_cnt;
  int      total = 0;
  int      bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_q.delete();
    m_cnt = 0;
  endtask

  // One clock: drive inputs at the falling edge, check the combinational
  // outputs, then advance the model across the rising edge and check the rest.
  task automatic step(input logic v, input logic [31:0] pc, input logic rv, input logic rt);
    int     idx;
    int     sz;
    logic   ptake;
    logic   mis;
    entry_t e;
    @(negedge clk);
    pred_valid = v;
    pred_pc    = pc;
    res_valid  = rv;
    res_take   = rt;
    #1;
    idx   = (pc >> 2) % ENTRIES;
    ptake = (m_ctr[idx] >= 2);
    check("pred_take", {63'd0, pred_take}, {63'd0, ptake});
    check("pred_ready", {63'd0, pred_ready}, {63'd0, m_q.size() < DEPTH});
    @(posedge clk);
    #1;
    sz  = m_q.size();
    mis = 1'b0;
    if (rv && sz > 0) begin
      e = m_q.pop_front();
      if (rt) m_ctr[e.idx] = (m_ctr[e.idx] == 3) ? 3 : m_ctr[e.idx] + 1;
      else    m_ctr[e.idx] = (m_ctr[e.idx] == 0) ? 0 : m_ctr[e.idx] - 1;
      mis = (rt != e.pred);
    end
    if (v && sz < DEPTH) m_q.push_back('{idx, ptake});
    if (mis) begin
      m_q.delete();
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end
    check("mispredict", {63'd0, mispredict}, {63'd0, mis});
    check("underflow", {63'd0, underflow}, {63'd0, rv && sz == 0});
    check("occupancy", {61'd0, occupancy}, 64'(m_q.size()));
    check("mispred_cnt", {32'd0, mispred_cnt}, 64'(m_cnt));
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_occupancy", {61'd0, occupancy}, 64'd0);
    check("rst_mispredict", {63'd0, mispredict}, 64'd0);
    check("rst_underflow", {63'd0, underflow}, 64'd0);
    check("rst_cnt", {32'd0, mispred_cnt}, 64'd0);
    check("rst_ready", {63'd0, pred_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // First branch predicted not-taken, resolves taken, then the pulse drops.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b0, 32'h100, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("first_pred_taken", {63'd0, m_q[0].pred}, 64'd1);

    // Saturation at strongly taken, then a single not-taken.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h100, 1'b1, 1'b1);
      step(1'b1, 32'h100, 1'b0, 1'b0);
    end
    step(1'b0, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h100, 1'b0, 1'b0);

    // Fill, blocked push, push while popping at full, then at three deep.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i * 4 + 32'h100), 1'b0, 1'b0);
    check("full_occupancy", {61'd0, occupancy}, 64'd4);
    step(1'b1, 32'h114, 1'b0, 1'b0);
    step(1'b1, 32'h114, 1'b1, 1'b0);
    step(1'b1, 32'h118, 1'b1, 1'b0);

    // Mispredict on the oldest with a same-cycle push flushes everything.
    step(1'b1, 32'h11c, 1'b1, 1'b1);
    check("flush_occupancy", {61'd0, occupancy}, 64'd0);

    // Resolve with nothing in flight, then confirm table state untouched.
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h100, 1'b0, 1'b0);
    step(1'b0, 32'h104, 1'b0, 1'b0);

    // Async reset with two entries in flight.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_occupancy", {61'd0, occupancy}, 64'd0);
    check("async_cnt", {32'd0, mispred_cnt}, 64'd0);
    check("async_mispredict", {63'd0, mispredict}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) step(1'b0, 32'(i * 4), 1'b0, 1'b0);

    // Random traffic over a few colliding indices.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           {$urandom_range(0, 255) % 16, 8'h0, 4'($urandom_range(0, 7)), 2'b00} | 32'h0,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
